// File: rtl/ldr_sdram_writer_if.sv
// ldr_sdram_writer_if
//   Bundles the ROM-image loader handshake and the SDRAM arbiter write port
//   seen by ldr_sdram_writer.
//   Loader side : ldr_aen, ldr_addr[19:0], ldr_wdat[7:0], ldr_wr -> ldr_ack
//   Memory side : mem_req, mem_addr[ADDR_W-1:0], mem_wdat[15:0], mem_be[1:0] <- mem_ack
//   Status      : busy
//   master : the environment (loader initiator + SDRAM arbiter)
//   slave  : the writer itself
interface ldr_sdram_writer_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              ldr_aen;
    logic [19:0]       ldr_addr;
    logic [7:0]        ldr_wdat;
    logic              ldr_wr;
    logic              ldr_ack;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdat;
    logic [1:0]        mem_be;
    logic              mem_ack;
    logic              busy;

    modport master (
        output ldr_aen, ldr_addr, ldr_wdat, ldr_wr, mem_ack,
        input  ldr_ack, mem_req, mem_addr, mem_wdat, mem_be, busy
    );

    modport slave (
        input  ldr_aen, ldr_addr, ldr_wdat, ldr_wr, mem_ack,
        output ldr_ack, mem_req, mem_addr, mem_wdat, mem_be, busy
    );
endinterface

// File: rtl/ldr_sdram_writer.sv
// ldr_sdram_writer
//   Responder end of the ROM-image loader handshake. Accepts one byte per
//   ldr_wr request, packs big-endian byte pairs into 16-bit words and writes
//   them to the SDRAM arbiter at BASE_ADDR + byte offset / 2.
//   clk_sys : system clock, rising edge
//   reset   : asynchronous, active-high
//   bus     : loader handshake + SDRAM write port + busy (slave modport)
module ldr_sdram_writer #(
    parameter int unsigned          ADDR_W    = 24,
    parameter logic [ADDR_W-1:0]    BASE_ADDR = ADDR_W'(24'h780000)
) (
    input  logic               clk_sys,
    input  logic               reset,
    ldr_sdram_writer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        FLUSH,
        ACK,
        RELEASE
    } state_t;

    state_t            state_q, state_d;
    logic              pv_q, pv_d;
    logic [ADDR_W-1:0] pw_q, pw_d;
    logic [7:0]        pd_q, pd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_wdat_q, mem_wdat_d;
    logic [1:0]        mem_be_q, mem_be_d;

    logic [ADDR_W-1:0] word_addr;

    assign word_addr = BASE_ADDR + ADDR_W'(bus.ldr_addr[19:1]);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pv_q       <= 1'b0;
            pw_q       <= '0;
            pd_q       <= '0;
            mem_addr_q <= '0;
            mem_wdat_q <= '0;
            mem_be_q   <= '0;
        end else begin
            state_q    <= state_d;
            pv_q       <= pv_d;
            pw_q       <= pw_d;
            pd_q       <= pd_d;
            mem_addr_q <= mem_addr_d;
            mem_wdat_q <= mem_wdat_d;
            mem_be_q   <= mem_be_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pv_d       = pv_q;
        pw_d       = pw_q;
        pd_d       = pd_q;
        mem_addr_d = mem_addr_q;
        mem_wdat_d = mem_wdat_q;
        mem_be_d   = mem_be_q;

        unique case (state_q)
            IDLE: begin
                if (bus.ldr_aen && bus.ldr_wr) begin
                    if (!bus.ldr_addr[0]) begin
                        if (!pv_q) begin
                            pd_d    = bus.ldr_wdat;
                            pw_d    = word_addr;
                            pv_d    = 1'b1;
                            state_d = ACK;
                        end else begin
                            // Orphaned even byte goes out first; ldr_wr is
                            // still high so the new byte is retried from IDLE.
                            mem_addr_d = pw_q;
                            mem_wdat_d = {pd_q, 8'h00};
                            mem_be_d   = 2'b10;
                            state_d    = FLUSH;
                        end
                    end else begin
                        if (pv_q && (pw_q == word_addr)) begin
                            mem_addr_d = word_addr;
                            mem_wdat_d = {pd_q, bus.ldr_wdat};
                            mem_be_d   = 2'b11;
                            pv_d       = 1'b0;
                            state_d    = WRITE;
                        end else if (pv_q) begin
                            mem_addr_d = pw_q;
                            mem_wdat_d = {pd_q, 8'h00};
                            mem_be_d   = 2'b10;
                            state_d    = FLUSH;
                        end else begin
                            mem_addr_d = word_addr;
                            mem_wdat_d = {8'h00, bus.ldr_wdat};
                            mem_be_d   = 2'b01;
                            state_d    = WRITE;
                        end
                    end
                end else if (!bus.ldr_aen && pv_q) begin
                    // End of image with a half-filled word: write it, no ack.
                    mem_addr_d = pw_q;
                    mem_wdat_d = {pd_q, 8'h00};
                    mem_be_d   = 2'b10;
                    state_d    = FLUSH;
                end
            end
            WRITE: begin
                if (bus.mem_ack) state_d = ACK;
            end
            FLUSH: begin
                if (bus.mem_ack) begin
                    pv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            ACK: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Hold off until the initiator drops ldr_wr so a lingering
                // request is never consumed twice.
                if (!bus.ldr_wr) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_req  = (state_q == WRITE) || (state_q == FLUSH);
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdat = mem_wdat_q;
    assign bus.mem_be   = mem_be_q;
    assign bus.ldr_ack  = (state_q == ACK);
    assign bus.busy     = (state_q != IDLE) || pv_q;

endmodule
